arb7_rr_sched: RTL
==================

# arb7_rr_sched

Round-robin scheduler that shares one datapath resource among seven requesters and drives the resource's 3-bit select code. It uses the team's 3-to-8 decode convention: code 0 means no owner, and code n (1..7) means requester n-1 owns the resource. A registered one-hot grant vector carries the same information. The block sits between the requester ports and the shared resource's select/decoder input.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive cycles one owner may hold the grant when the timeout feature is compiled in. Legal range 2..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req` in 7: request lines; `req[k]` belongs to requester k.
- `rel` in 1: release strobe from the current owner. Sampled only in GRANT.
- `gnt_code` out 3: owner code. 0 means none; k+1 means requester k.
- `gnt` out 7: one-hot grant. `gnt[k]` is 1 iff `gnt_code == k+1`.
- `busy` out 1: high while in GRANT.
- `tmo` out 1: one-cycle pulse when a grant is force-ended by timeout.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner holds the resource.
  - GAP: one-cycle turnaround with no owner.
- Pointer `last` (3 bits, values 0..6) records the most recently served requester.
- Winner selection: the first k with `req[k]=1`, searching `last+1`, `last+2`, … modulo 7 and wrapping 6→0. `last` itself is checked last.
- IDLE or GAP, with `|req` = 1 at the edge: go to GRANT. At the same edge:
  - `owner` ← winner
  - `gnt_code` ← winner+1
  - `gnt` ← one-hot(winner)
  - `busy` ← 1
  - hold counter ← 0
- IDLE or GAP, with `|req` = 0: go to IDLE (or stay in IDLE). All grant outputs are 0.
- GRANT ends at an edge where any of the following is true:
  - `rel` = 1, or
  - `req[owner]` = 0, or
  - the timeout condition holds.
- On the GRANT exit edge:
  - next state is GAP
  - `gnt_code` ← 0, `gnt` ← 0, `busy` ← 0
  - `last` ← owner
- Otherwise GRANT is held and the hold counter increments.
- `rel` in IDLE or GAP is ignored.
- Simultaneous `rel` and timeout count as one release. `tmo` is still pulsed.
- Requests from non-owners never preempt the current owner.
- Code/vector consistency is invariant: `gnt` is never multi-hot, and `gnt` = 0 iff `gnt_code` = 0.

## Timing
- All outputs are registered.
- Reset values:
  - `gnt_code` = 0, `gnt` = 0, `busy` = 0, `tmo` = 0
  - state = IDLE
  - `last` = 6, so requester 0 has first priority
  - hold counter = 0
- Reset mid-GRANT drops the grant at that edge, with no GAP cycle.
- Grant latency: `req` sampled high at edge t gives the grant visible after edge t, i.e. one cycle.
- Release latency: `rel` or a `req` drop sampled at edge t clears the grant after edge t.
- The minimum spacing between two different owners is one GAP cycle. Back-to-back service therefore repeats every (hold + 1) cycles.
- A requester whose `req` stays high after release is re-considered at the GAP edge. It wins again only if no other requester is asserting.

## Configuration
- Macro `ARB7_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter is present.
  - GRANT is force-ended at the edge where the counter equals `MAX_HOLD-1`, so an owner holds for at most `MAX_HOLD` cycles.
  - `tmo` is 1 during the following GAP cycle only.
- Undefined:
  - No counter is instantiated.
  - `tmo` is tied to 0.
  - A grant lasts until `rel` or a `req` drop, so it may be unbounded.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `req`=7'h7F. Outputs stay 0. After release, the first grant is `gnt_code`=1, `gnt`=7'h01.
- Single requester: `req`=7'h08. One cycle later `gnt_code`=4, `gnt`=7'h08, `busy`=1. Drop `req[3]`: the next cycle is a GAP with all outputs 0.
- Rotation: `req`=7'h7F with `rel` pulsed each GRANT cycle. `gnt_code` sequence is 1,0,2,0,…,7,0,1, wrapping after requester 6.
- Wrap and skip: set `last`=5 via a grant to requester 5, then `req`=7'h05. The next owner is 0 (code 1), then 2 (code 3).
- Timeout with `ARB7_TIMEOUT_EN`, `MAX_HOLD`=4, `req`=7'h03, no `rel`:
  - code 1 for 4 cycles
  - GAP with `tmo`=1
  - code 2 for 4 cycles
  - Without the macro, code 1 is held indefinitely and `tmo` is always 0.
- Reset mid-grant: assert `rst_n`=0 while `gnt_code`=3. At the next edge all outputs are 0 and `last`=6.

Source files
------------

// File: rtl/arb7_rr_sched.sv
// -----------------------------------------------------------------------------
// arb7_rr_sched
// Round-robin scheduler that shares one datapath resource among seven
// requesters. It drives the resource's 3-bit select code, where 0 means no
// owner and n (1..7) means requester n-1 owns the resource. It also drives a
// matching one-hot grant vector. A one-cycle GAP with no owner separates any
// two grants.
//
// Optional feature macro: ARB7_TIMEOUT_EN
//   defined   : an 8-bit hold counter force-ends a grant after MAX_HOLD cycles
//               and pulses tmo during the following GAP cycle
//   undefined : no counter is built, tmo is tied to 0, and grants are unbounded
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles with the timeout (2..255)
//
// Ports
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   req[6:0]  request lines, req[k] belongs to requester k
//   rel       release strobe from the current owner (only honoured in GRANT)
//   gnt_code  owner code: 0 = none, k+1 = requester k
//   gnt[6:0]  one-hot grant, gnt[k] set iff gnt_code == k+1
//   busy      high while a grant is held
//   tmo       one-cycle pulse in the GAP after a timeout-ended grant
// -----------------------------------------------------------------------------
module arb7_rr_sched #(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] req,
   input  logic       rel,
   output logic [2:0] gnt_code,
   output logic [6:0] gnt,
   output logic       busy,
   output logic       tmo
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Catch an out-of-range hold limit at elaboration time.
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("arb7_rr_sched: MAX_HOLD must be in 2..255");
   end

   // Round-robin search starting just after 'last' and wrapping 6 -> 0.
   // Returns {found, index}; 'last' itself is examined last.
   function automatic logic [3:0] pick_winner(input logic [6:0] r,
                                              input logic [2:0] last);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'd0;
      idx = last;
      for (int i = 0; i < 7; i++) begin
         idx = (idx == 3'd6) ? 3'd0 : idx + 3'd1;
         if (!res[3] && r[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   // One-hot expansion of a requester index; index 7 yields all zeros.
   function automatic logic [6:0] onehot7(input logic [2:0] idx);
      return 7'(8'd1 << idx);
   endfunction

   state_t     state_r, state_s;
   logic [2:0] owner_r, owner_s;
   logic [2:0] last_r,  last_s;
   logic [2:0] gnt_code_r, gnt_code_s;
   logic [6:0] gnt_r, gnt_s;
   logic       busy_r, busy_s;
   logic [3:0] win_s;
   logic       timeout_s;
   logic       end_s;

`ifdef ARB7_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] hold_r, hold_s;
   logic       tmo_r, tmo_s;

   // Grant is force-ended on the edge where the counter reaches MAX_HOLD-1.
   assign timeout_s = (state_r == ST_GRANT) && (hold_r == HOLD_LAST);
   assign tmo       = tmo_r;
`else
   assign timeout_s = 1'b0;
   assign tmo       = 1'b0;
`endif

   assign win_s = pick_winner(req, last_r);
   assign end_s = rel || !req[owner_r] || timeout_s;

   // Next-state and next-output decode.
   always_comb begin
      state_s    = state_r;
      owner_s    = owner_r;
      last_s     = last_r;
      gnt_code_s = gnt_code_r;
      gnt_s      = gnt_r;
      busy_s     = busy_r;
`ifdef ARB7_TIMEOUT_EN
      hold_s     = hold_r;
      tmo_s      = 1'b0;
`endif
      case (state_r)
         ST_IDLE, ST_GAP: begin
            if (win_s[3]) begin
               state_s    = ST_GRANT;
               owner_s    = win_s[2:0];
               gnt_code_s = win_s[2:0] + 3'd1;
               gnt_s      = onehot7(win_s[2:0]);
               busy_s     = 1'b1;
`ifdef ARB7_TIMEOUT_EN
               hold_s     = 8'd0;
`endif
            end else begin
               state_s    = ST_IDLE;
               gnt_code_s = 3'd0;
               gnt_s      = 7'd0;
               busy_s     = 1'b0;
            end
         end
         ST_GRANT: begin
            if (end_s) begin
               // rel and timeout together count as one release
               state_s    = ST_GAP;
               last_s     = owner_r;
               gnt_code_s = 3'd0;
               gnt_s      = 7'd0;
               busy_s     = 1'b0;
`ifdef ARB7_TIMEOUT_EN
               tmo_s      = timeout_s;
`endif
            end else begin
`ifdef ARB7_TIMEOUT_EN
               hold_s     = hold_r + 8'd1;
`endif
               state_s    = ST_GRANT;
            end
         end
         default: begin
            state_s    = ST_IDLE;
            gnt_code_s = 3'd0;
            gnt_s      = 7'd0;
            busy_s     = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset drops any grant with no GAP.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         owner_r    <= 3'd0;
         last_r     <= 3'd6;
         gnt_code_r <= 3'd0;
         gnt_r      <= 7'd0;
         busy_r     <= 1'b0;
`ifdef ARB7_TIMEOUT_EN
         hold_r     <= 8'd0;
         tmo_r      <= 1'b0;
`endif
      end else begin
         state_r    <= state_s;
         owner_r    <= owner_s;
         last_r     <= last_s;
         gnt_code_r <= gnt_code_s;
         gnt_r      <= gnt_s;
         busy_r     <= busy_s;
`ifdef ARB7_TIMEOUT_EN
         hold_r     <= hold_s;
         tmo_r      <= tmo_s;
`endif
      end
   end

   assign gnt_code = gnt_code_r;
   assign gnt      = gnt_r;
   assign busy     = busy_r;

endmodule
